// File: rtl/pke_pkg.sv
// rtl/pke_pkg.sv - shared codes and constants for the packet key extractor
// Flit header codes, ethertypes of interest, class codes and the reset-time
// PCP-to-class map (3-bit classes, PCP 0 in the low field).
package pke_pkg;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  localparam logic [15:0] ETH_PTP  = 16'h88F7;
  localparam logic [15:0] ETH_VLAN = 16'h8100;

  typedef enum logic [1:0] {
    CLS_BE  = 2'd0,
    CLS_RB  = 2'd1,
    CLS_PTP = 2'd2,
    CLS_TSN = 2'd3
  } pkt_class_e;

  // PCP 0-2 -> BE, 3-5 -> RB, 6-7 -> TSN
  localparam logic [23:0] DEFAULT_PCP_MAP = 24'h6C9200;

endpackage

// File: rtl/pke_res_fifo.sv
// rtl/pke_res_fifo.sv - 4-deep result FIFO of {type, key}
// Ports: clk, rst_n (async, active-low); push/push_data write an entry;
// pop retires the entry shown on front; empty flags no stored entry.
module pke_res_fifo
  import pke_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] front,
  output logic         empty
);

  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic [2:0]   count;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 3'd0);
  assign front   = mem[rd_ptr];
  assign do_push = push && (count != 3'd4);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      if (do_push && !do_pop)      count <= count + 3'd1;
      else if (do_pop && !do_push) count <= count - 3'd1;
    end
  end

endmodule

// File: rtl/pke_flex.sv
// rtl/pke_flex.sv - packet classifier and key extractor with fixed-latency flit forwarding
// Ports: clk, rst_n (async, active-low); in_data/in_data_wr flits in,
// in_valid_wr per-packet strobe; cfg_pcp_map/cfg_untag_type class config;
// out_data/out_data_wr flits delayed by MD_FLITS+1; out_pkttype/out_key
// valid from head to tail on the output; out_valid/out_valid_wr with the
// output tail; pktin/pktout/short/err saturating counters.
module pke_flex
  import pke_pkg::*;
#(
  parameter int MD_FLITS = 2,
  parameter int INPORT_W = 6,
  parameter int TYPE_W   = 3,
  parameter int KEY_W    = INPORT_W + 96
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [133:0]        in_data,
  input  logic                in_data_wr,
  input  logic                in_valid_wr,
  input  logic [8*TYPE_W-1:0] cfg_pcp_map,
  input  logic [TYPE_W-1:0]   cfg_untag_type,
  output logic [133:0]        out_data,
  output logic                out_data_wr,
  output logic                out_valid,
  output logic                out_valid_wr,
  output logic [TYPE_W-1:0]   out_pkttype,
  output logic [KEY_W-1:0]    out_key,
  output logic [63:0]         pktin_cnt,
  output logic [63:0]         pktout_cnt,
  output logic [31:0]         short_cnt,
  output logic [31:0]         err_cnt
);

  localparam int         L       = MD_FLITS + 1;
  localparam int         RES_W   = TYPE_W + KEY_W;
  localparam logic [2:0] MD_IDX  = 3'(MD_FLITS);
  localparam logic [2:0] AGE_MAX = 3'(L - 1);
  localparam logic [2:0] AGE_OK  = 3'(L - 2);

  // Delay line; dl_hr marks the head entry of a packet that owns a result.
  // The last stage never needs the flag, so dl_hr stops one short.
  logic [133:0] dl_data [L];
  logic         dl_wr   [L];
  logic         dl_hr   [L-1];

  logic                open_q;
  logic [2:0]          idx_q;
  logic [2:0]          age_q;      // cycles since the open head entered stage 0
  logic [INPORT_W-1:0] inport_q;
  logic                out_open_q;

  logic in_head, in_tail;
  assign in_head = in_data_wr && (in_data[133:132] == HEAD);
  assign in_tail = in_data_wr && (in_data[133:132] == TAIL);

  logic              res_valid, res_push, short_hit;
  logic [TYPE_W-1:0] res_type;
  logic [KEY_W-1:0]  res_key;
  logic [2:0]        pcp;

  always_comb begin
    res_valid = 1'b0;
    short_hit = 1'b0;
    res_type  = '0;
    res_key   = '0;
    pcp       = in_data[15:13];
    if (in_data_wr && !in_head && open_q) begin
      if (idx_q == MD_IDX) begin
        res_valid = 1'b1;
        res_key   = {in_data[127:32], inport_q};
        if (in_data[31:16] == ETH_PTP)       res_type = TYPE_W'(CLS_PTP);
        else if (in_data[31:16] == ETH_VLAN) res_type = cfg_pcp_map[int'(pcp)*TYPE_W +: TYPE_W];
        else                                 res_type = cfg_untag_type;
      end else if (in_tail && (idx_q < MD_IDX)) begin
        res_valid = 1'b1;
        short_hit = 1'b1;
        res_key   = {96'h0, inport_q};
        res_type  = TYPE_W'(CLS_BE);
      end
    end
  end

  // A result is only usable while its head has not yet reached the output
  // stage; otherwise it would desynchronise the FIFO from the flagged heads.
  assign res_push = res_valid && (age_q <= AGE_OK);

  // View of the entry about to be loaded into the output stage.
  logic e_head, e_tail, e_hr;
  assign e_head = dl_wr[L-2] && (dl_data[L-2][133:132] == HEAD);
  assign e_tail = dl_wr[L-2] && (dl_data[L-2][133:132] == TAIL);
  assign e_hr   = dl_hr[L-2] || (res_push && (age_q == AGE_OK));

  logic             fifo_empty, fifo_push, fifo_pop, bypass;
  logic [RES_W-1:0] fifo_front;

  // With no gaps the header is classified in the same cycle its head
  // moves to the output stage, so the result skips the FIFO.
  assign bypass    = e_head && e_hr && fifo_empty;
  assign fifo_pop  = e_head && e_hr && !fifo_empty;
  assign fifo_push = res_push && !bypass;

  pke_res_fifo #(.W(RES_W)) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({res_type, res_key}),
    .pop       (fifo_pop),
    .front     (fifo_front),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        dl_data[i] <= '0;
        dl_wr[i]   <= 1'b0;
      end
      for (int i = 0; i < L - 1; i++) dl_hr[i] <= 1'b0;
    end else begin
      dl_data[0] <= in_data;
      dl_wr[0]   <= in_data_wr;
      dl_hr[0]   <= 1'b0;
      for (int i = 1; i < L; i++) begin
        dl_data[i] <= dl_data[i-1];
        dl_wr[i]   <= dl_wr[i-1];
      end
      for (int i = 1; i < L - 1; i++)
        dl_hr[i] <= dl_hr[i-1] || (res_push && (age_q == 3'(i - 1)));
    end
  end

  assign out_data    = dl_data[L-1];
  assign out_data_wr = dl_wr[L-1];
  assign out_valid   = out_valid_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q    <= 1'b0;
      idx_q     <= '0;
      age_q     <= '0;
      inport_q  <= '0;
      err_cnt   <= '0;
      short_cnt <= '0;
      pktin_cnt <= '0;
    end else begin
      if (in_head) begin
        if (open_q && (err_cnt != '1)) err_cnt <= err_cnt + 32'd1;
        open_q   <= 1'b1;
        idx_q    <= 3'd1;
        age_q    <= '0;
        inport_q <= in_data[120 +: INPORT_W];
      end else begin
        if (age_q < AGE_MAX) age_q <= age_q + 3'd1;
        if (in_data_wr && open_q) begin
          if (in_tail) open_q <= 1'b0;
          if (idx_q <= MD_IDX) idx_q <= idx_q + 3'd1;
        end
      end
      if (short_hit && (short_cnt != '1)) short_cnt <= short_cnt + 32'd1;
      if (in_valid_wr && (pktin_cnt != '1)) pktin_cnt <= pktin_cnt + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pkttype  <= '0;
      out_key      <= '0;
      out_valid_wr <= 1'b0;
      out_open_q   <= 1'b0;
      pktout_cnt   <= '0;
    end else begin
      out_valid_wr <= 1'b0;
      if (e_head) begin
        out_open_q <= e_hr;
        if (e_hr) begin
          if (fifo_empty) {out_pkttype, out_key} <= {res_type, res_key};
          else            {out_pkttype, out_key} <= fifo_front;
        end
      end else if (e_tail && out_open_q) begin
        out_open_q   <= 1'b0;
        out_valid_wr <= 1'b1;
        if (pktout_cnt != '1) pktout_cnt <= pktout_cnt + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_pke_flex.sv
// tb/tb_pke_flex.sv - directed self-checking bench for pke_flex
module tb_pke_flex;

  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] M = 2'b11;
  localparam logic [1:0] T = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [133:0] in_data;
  logic         in_data_wr;
  logic         in_valid_wr;
  logic [23:0]  cfg_pcp_map;
  logic [2:0]   cfg_untag_type;
  logic [133:0] out_data;
  logic         out_data_wr;
  logic         out_valid;
  logic         out_valid_wr;
  logic [2:0]   out_pkttype;
  logic [101:0] out_key;
  logic [63:0]  pktin_cnt;
  logic [63:0]  pktout_cnt;
  logic [31:0]  short_cnt;
  logic [31:0]  err_cnt;

  always #5 clk = ~clk;

  pke_flex #(.MD_FLITS(2), .INPORT_W(6), .TYPE_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_data_wr     (in_data_wr),
    .in_valid_wr    (in_valid_wr),
    .cfg_pcp_map    (cfg_pcp_map),
    .cfg_untag_type (cfg_untag_type),
    .out_data       (out_data),
    .out_data_wr    (out_data_wr),
    .out_valid      (out_valid),
    .out_valid_wr   (out_valid_wr),
    .out_pkttype    (out_pkttype),
    .out_key        (out_key),
    .pktin_cnt      (pktin_cnt),
    .pktout_cnt     (pktout_cnt),
    .short_cnt      (short_cnt),
    .err_cnt        (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic         h_wr [0:63];
  logic [133:0] h_d  [0:63];
  int           n = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [133:0] mk_meta(input logic [1:0] code, input logic [5:0] port);
    return {code, 6'h0, port, 120'h0};
  endfunction

  function automatic logic [133:0] mk_hdr(input logic [1:0] code, input logic [95:0] addr,
                                          input logic [15:0] et, input logic [2:0] pcp);
    return {code, 4'h0, addr, et, pcp, 13'h0};
  endfunction

  function automatic logic [133:0] mk_plain(input logic [1:0] code, input logic [31:0] v);
    return {code, 100'h0, v};
  endfunction

  // One input cycle; afterwards the output must equal the flit driven 3 cycles earlier.
  task automatic drive(input logic wr, input logic [133:0] d, input logic v);
    in_data_wr  = wr;
    in_data     = d;
    in_valid_wr = v;
    @(posedge clk);
    #1;
    h_wr[n] = wr;
    h_d[n]  = d;
    n++;
    if (n >= 3) begin
      check("delay_wr", out_data_wr, h_wr[n-3]);
      if (h_wr[n-3]) check("delay_data", out_data, h_d[n-3]);
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  logic [95:0] a_a, a_b, a_c, a_f, a_h;

  initial begin
    a_a = 96'hA0A1A2A3A4A5B0B1B2B3B4B5;
    a_b = 96'h0123456789AB_CDEF01234567;
    a_c = 96'hFEDCBA987654_3210FEDCBA98;
    a_f = 96'h111122223333_444455556666;
    a_h = 96'hC0FFEE000001_BADC0DE00002;

    rst_n          = 1'b0;
    in_data        = '0;
    in_data_wr     = 1'b0;
    in_valid_wr    = 1'b0;
    cfg_pcp_map    = 24'h6C9200;
    cfg_untag_type = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_wr", out_data_wr, 1'b0);
    check("rst_data", out_data, 134'h0);
    check("rst_valid_wr", out_valid_wr, 1'b0);
    check("rst_type", out_pkttype, 3'd0);
    check("rst_key", out_key, 102'h0);
    check("rst_pktin", pktin_cnt, 64'd0);
    check("rst_pktout", pktout_cnt, 64'd0);
    rst_n = 1'b1;

    // VLAN PCP 6, inport 5
    drive(1'b1, mk_meta(H, 6'd5), 1'b0);
    drive(1'b1, mk_plain(M, 32'h1111), 1'b0);
    drive(1'b1, mk_hdr(M, a_a, 16'h8100, 3'd6), 1'b0);
    check("a_type", out_pkttype, 3'd3);
    check("a_key", out_key, {a_a, 6'd5});
    check("a_vwr_head", out_valid_wr, 1'b0);
    drive(1'b1, mk_plain(T, 32'hAAAA), 1'b1);
    idle();
    idle();
    check("a_vwr_tail", out_valid_wr, 1'b1);
    check("a_valid", out_valid, 1'b1);
    check("a_pktout", pktout_cnt, 64'd1);
    check("a_pktin", pktin_cnt, 64'd1);
    idle();
    check("a_vwr_after", out_valid_wr, 1'b0);
    check("a_key_hold", out_key, {a_a, 6'd5});

    // PTP then untagged IPv4, back to back with gaps after the header
    cfg_untag_type = 3'd1;
    drive(1'b1, mk_meta(H, 6'd9), 1'b0);
    drive(1'b1, mk_plain(M, 32'h2222), 1'b0);
    drive(1'b1, mk_hdr(M, a_b, 16'h88F7, 3'd0), 1'b0);
    check("b_type", out_pkttype, 3'd2);
    check("b_key", out_key, {a_b, 6'd9});
    idle();
    drive(1'b1, mk_plain(T, 32'hBBBB), 1'b1);
    drive(1'b1, mk_meta(H, 6'd33), 1'b0);
    drive(1'b1, mk_plain(M, 32'h3333), 1'b0);
    check("b_vwr_tail", out_valid_wr, 1'b1);
    drive(1'b1, mk_hdr(M, a_c, 16'h0800, 3'd7), 1'b0);
    check("c_type", out_pkttype, 3'd1);
    check("c_key", out_key, {a_c, 6'd33});
    check("c_vwr_head", out_valid_wr, 1'b0);
    idle();
    drive(1'b1, mk_plain(M, 32'h4444), 1'b0);
    idle();
    drive(1'b1, mk_plain(T, 32'hCCCC), 1'b1);
    idle();
    idle();
    check("c_vwr_tail", out_valid_wr, 1'b1);
    check("c_pktout", pktout_cnt, 64'd3);
    idle();

    // Short packet: tail at index 1
    drive(1'b1, mk_meta(H, 6'd12), 1'b0);
    drive(1'b1, mk_plain(T, 32'hDDDD), 1'b1);
    idle();
    check("d_type", out_pkttype, 3'd0);
    check("d_key", out_key, {96'h0, 6'd12});
    check("d_short", short_cnt, 32'd1);
    idle();
    check("d_vwr_tail", out_valid_wr, 1'b1);
    check("d_pktout", pktout_cnt, 64'd4);
    idle();

    // Head before tail: first packet aborted, second is VLAN PCP 3
    drive(1'b1, mk_meta(H, 6'd7), 1'b0);
    drive(1'b1, mk_plain(M, 32'h5555), 1'b0);
    drive(1'b1, mk_meta(H, 6'd20), 1'b0);
    check("e_err", err_cnt, 32'd1);
    check("e_type_hold", out_pkttype, 3'd0);
    check("e_key_hold", out_key, {96'h0, 6'd12});
    drive(1'b1, mk_plain(M, 32'h6666), 1'b0);
    drive(1'b1, mk_hdr(M, a_f, 16'h8100, 3'd3), 1'b0);
    check("f_type", out_pkttype, 3'd1);
    check("f_key", out_key, {a_f, 6'd20});
    check("e_no_pulse", pktout_cnt, 64'd4);
    drive(1'b1, mk_plain(T, 32'hFFFF), 1'b1);
    idle();
    idle();
    check("f_vwr_tail", out_valid_wr, 1'b1);
    check("f_pktout", pktout_cnt, 64'd5);
    check("f_pktin", pktin_cnt, 64'd5);
    check("f_short", short_cnt, 32'd1);

    // Reset in the middle of a packet
    drive(1'b1, mk_meta(H, 6'd2), 1'b0);
    drive(1'b1, mk_plain(M, 32'h7777), 1'b0);
    rst_n = 1'b0;
    in_data_wr = 1'b0;
    in_data = '0;
    #2;
    check("r_key", out_key, 102'h0);
    check("r_type", out_pkttype, 3'd0);
    check("r_data", out_data, 134'h0);
    check("r_pktin", pktin_cnt, 64'd0);
    check("r_pktout", pktout_cnt, 64'd0);
    check("r_err", err_cnt, 32'd0);
    check("r_short", short_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    cfg_pcp_map = 24'h6C9218;
    drive(1'b1, mk_meta(H, 6'd44), 1'b0);
    drive(1'b1, mk_plain(M, 32'h8888), 1'b0);
    drive(1'b1, mk_hdr(M, a_h, 16'h8100, 3'd1), 1'b0);
    check("h_type", out_pkttype, 3'd3);
    check("h_key", out_key, {a_h, 6'd44});
    drive(1'b1, mk_plain(T, 32'h9999), 1'b1);
    idle();
    idle();
    check("h_vwr_tail", out_valid_wr, 1'b1);
    check("h_pktout", pktout_cnt, 64'd1);
    check("h_pktin", pktin_cnt, 64'd1);
    check("h_err", err_cnt, 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
